// File: rtl/uart_loader.sv
// UART program loader: receives a framed image over 8N1 serial, writes little-endian words
// to instruction memory, and gates the CPU until the image checksum has been verified.
module uart_loader #(
   parameter int unsigned CLK_FREQ       = 27000000,
   parameter int unsigned BAUD           = 115200,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned TIMEOUT_CYCLES = 2700000,
   parameter bit          BOOT_ENABLE    = 1'b1,
   parameter logic [7:0]  MAGIC          = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_rx,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  cpu_enable,
   output logic                  busy,
   output logic                  error,
   output logic [5:0]            led
);

   localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
   localparam int unsigned HalfBit    = ClksPerBit / 2;
   localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
   localparam int unsigned Bytes      = DATA_WIDTH / 8;
   localparam int unsigned BiW        = (Bytes > 1) ? $clog2(Bytes) : 1;
   localparam int unsigned WcW        = ADDR_WIDTH + 1;
   localparam int unsigned TmoW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [16:0] MaxLen     = 17'(2 ** ADDR_WIDTH);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StCheck, StDone, StError} state_e;

   // ---------------- RX front end ----------------
   logic            rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e       rx_state_q, rx_state_d;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            rx_valid, rx_ferr;
   logic [7:0]      rx_byte;

   assign rx_byte = rx_shift_q;

   // Bit-timing state machine: start re-check at half bit, then sample every full bit.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid   = 1'b0;
      rx_ferr    = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RxStart;
               rx_cnt_d   = '0;
            end
         end
         RxStart: begin
            if (rx_cnt_q == CntW'(HalfBit - 1)) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RxIdle : RxData;  // high here means a glitch
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxData: begin
            if (rx_cnt_q == CntW'(ClksPerBit - 1)) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RxStop;
               else                  rx_bit_d   = rx_bit_q + 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxStop: begin
            if (rx_cnt_q == CntW'(ClksPerBit - 1)) begin
               rx_state_d = RxIdle;
               rx_valid   = rx_sync_q;
               rx_ferr    = !rx_sync_q;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // Synchroniser and receiver registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_meta_q  <= uart_rx;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // ---------------- Frame parser ----------------
   state_e                state_q, state_d;
   logic [7:0]            len_lo_q, len_lo_d;
   logic [WcW-1:0]        len_q, len_d, word_cnt_q, word_cnt_d;
   logic [BiW-1:0]        byte_idx_q, byte_idx_d;
   logic [DATA_WIDTH-1:0] word_q, word_d, wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            chk_q, chk_d;
   logic                  we_q, we_d, cpu_q, cpu_d, err_q, err_d;
   logic [TmoW-1:0]       tmo_q, tmo_d;
   logic                  in_frame, timeout;
   logic [16:0]           len_full;

   assign in_frame = (state_q == StLenLo) || (state_q == StLenHi) ||
                     (state_q == StData)  || (state_q == StCheck);
   assign timeout  = in_frame && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
   assign len_full = {1'b0, rx_byte, len_lo_q};

   // Frame next-state; framing error beats timeout, which beats a received byte.
   always_comb begin
      state_d    = state_q;
      len_lo_d   = len_lo_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      wdata_d    = wdata_q;
      addr_d     = addr_q;
      chk_d      = chk_q;
      we_d       = 1'b0;
      cpu_d      = cpu_q;
      err_d      = err_q;
      tmo_d      = (in_frame && !rx_valid) ? tmo_q + 1'b1 : '0;
      if (in_frame && (rx_ferr || timeout)) begin
         state_d = StError;
         err_d   = 1'b1;
         cpu_d   = 1'b0;
      end else if (rx_valid) begin
         unique case (state_q)
            StIdle, StDone, StError: begin
               if (rx_byte == MAGIC) begin
                  state_d = StLenLo;
                  cpu_d   = 1'b0;
                  err_d   = 1'b0;
               end
            end
            StLenLo: begin
               len_lo_d = rx_byte;
               state_d  = StLenHi;
            end
            StLenHi: begin
               word_cnt_d = '0;
               byte_idx_d = '0;
               chk_d      = '0;
               len_d      = WcW'(len_full);
               if (len_full > MaxLen) begin
                  state_d = StError;
                  err_d   = 1'b1;
                  cpu_d   = 1'b0;
               end else if (len_full == '0) begin
                  state_d = StCheck;
               end else begin
                  state_d = StData;
               end
            end
            StData: begin
               word_d[8*byte_idx_q +: 8] = rx_byte;
               chk_d = chk_q ^ rx_byte;
               if (byte_idx_q == BiW'(Bytes - 1)) begin
                  we_d       = 1'b1;
                  addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
                  wdata_d    = word_d;
                  byte_idx_d = '0;
                  word_cnt_d = word_cnt_q + 1'b1;
                  if (word_cnt_d == len_q) state_d = StCheck;
               end else begin
                  byte_idx_d = byte_idx_q + 1'b1;
               end
            end
            StCheck: begin
               if (rx_byte == chk_q) begin
                  state_d = StDone;
                  cpu_d   = 1'b1;
               end else begin
                  state_d = StError;
                  err_d   = 1'b1;
                  cpu_d   = 1'b0;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Frame state and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         len_lo_q   <= '0;
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         wdata_q    <= '0;
         addr_q     <= '0;
         chk_q      <= '0;
         we_q       <= 1'b0;
         cpu_q      <= BOOT_ENABLE;
         err_q      <= 1'b0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         len_lo_q   <= len_lo_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         wdata_q    <= wdata_d;
         addr_q     <= addr_d;
         chk_q      <= chk_d;
         we_q       <= we_d;
         cpu_q      <= cpu_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign cpu_enable = cpu_q;
   assign busy       = in_frame;
   assign error      = err_q;
   assign led        = {~err_q, ~in_frame, ~addr_q[3:0]};

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: table of frames with a write scoreboard, plus hand-written
// sequences for timeout, framing error, glitch rejection and mid-frame reset.
module tb_uart_loader;
   localparam int unsigned Cpb = 32;
   localparam int unsigned Tmo = 2000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        uart_rx = 1'b1;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_enable, busy, error;
   logic [5:0]  led;

   uart_loader #(
      .CLK_FREQ      (Cpb * 115200),
      .BAUD          (115200),
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (10),
      .TIMEOUT_CYCLES(Tmo),
      .BOOT_ENABLE   (1'b1),
      .MAGIC         (8'hA5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .uart_rx   (uart_rx),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_enable(cpu_enable),
      .busy      (busy),
      .error     (error),
      .led       (led)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int               nb;
      logic [0:11][7:0] b;
      int               nw;
      logic [0:1][9:0]  a;
      logic [0:1][31:0] d;
      bit               e_err, e_cpu, e_busy;
   } vec_t;

   int         tests = 0;
   int         fails = 0;
   wr_t        exp_q[$];
   wr_t        exp_e;
   logic [3:0] last_addr = 4'h0;
   vec_t       vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %h data %h, none expected", mem_addr, mem_wdata);
         end else begin
            exp_e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(exp_e.addr));
            check("wr_data", mem_wdata, exp_e.data);
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop);
      uart_rx = 1'b0;
      wait_clks(Cpb);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         wait_clks(Cpb);
      end
      uart_rx = stop;
      wait_clks(Cpb);
      uart_rx = 1'b1;
      if (!stop) wait_clks(Cpb);
   endtask

   task automatic check_status(input string name, input bit e_err, input bit e_cpu,
                               input bit e_busy);
      @(negedge clk);
      check({name, "_error"}, 32'(error), 32'(e_err));
      check({name, "_cpu_enable"}, 32'(cpu_enable), 32'(e_cpu));
      check({name, "_busy"}, 32'(busy), 32'(e_busy));
      check({name, "_led"}, 32'(led), 32'({~e_err, ~e_busy, ~last_addr}));
   endtask

   task automatic do_reset();
      uart_rx = 1'b1;
      reset   = 1'b0;
      wait_clks(3);
      reset     = 1'b1;
      last_addr = 4'h0;
   endtask

   initial begin
      vecs[0] = '{12, {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD,
                       8'hDE, 8'h2A},
                  2, {10'd0, 10'd1}, {32'h12345678, 32'hDEADBEEF}, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{12, {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD,
                       8'hDE, 8'h01},
                  2, {10'd0, 10'd1}, {32'h12345678, 32'hDEADBEEF}, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{4, {8'hA5, 8'h00, 8'h00, 8'h00, 64'h0},
                  0, {10'd0, 10'd0}, {32'h0, 32'h0}, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{3, {8'hA5, 8'h01, 8'h04, 72'h0},
                  0, {10'd0, 10'd0}, {32'h0, 32'h0}, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{4, {8'hA5, 8'h00, 8'h00, 8'h00, 64'h0},
                  0, {10'd0, 10'd0}, {32'h0, 32'h0}, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8, {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 32'h0},
                  1, {10'd0, 10'd0}, {32'h44332211, 32'h0}, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{1, {8'h55, 88'h0},
                  0, {10'd0, 10'd0}, {32'h0, 32'h0}, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1, {8'hA5, 88'h0},
                  0, {10'd0, 10'd0}, {32'h0, 32'h0}, 1'b0, 1'b0, 1'b1};

      // Reset state, held and then released with the line idle.
      reset = 1'b0;
      wait_clks(3);
      @(negedge clk);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check_status("rst", 1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      wait_clks(2000);
      check_status("idle", 1'b0, 1'b1, 1'b0);

      // Table of frames.
      for (int v = 0; v < 8; v++) begin
         for (int w = 0; w < vecs[v].nw; w++) exp_q.push_back('{vecs[v].a[w], vecs[v].d[w]});
         for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].b[i], 1'b1);
         wait_clks(4);
         if (vecs[v].nw > 0) last_addr = vecs[v].a[vecs[v].nw-1][3:0];
         check_status($sformatf("vec%0d", v), vecs[v].e_err, vecs[v].e_cpu, vecs[v].e_busy);
         check($sformatf("vec%0d_writes_left", v), 32'(exp_q.size()), 32'd0);
      end

      // Inter-byte timeout inside DATA.
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      check_status("tmo_before", 1'b0, 1'b0, 1'b1);
      wait_clks(Tmo + 10);
      check_status("tmo_after", 1'b1, 1'b0, 1'b0);

      // Leave ERROR with MAGIC, then a bad stop bit inside DATA.
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      check_status("ferr_before", 1'b0, 1'b0, 1'b1);
      send_byte(8'h33, 1'b0);
      check_status("ferr_after", 1'b1, 1'b0, 1'b0);

      // Short low glitch in IDLE must not start a byte.
      do_reset();
      uart_rx = 1'b0;
      #100;
      uart_rx = 1'b1;
      wait_clks(3 * Cpb);
      check_status("glitch", 1'b0, 1'b1, 1'b0);
      send_byte(8'hA5, 1'b1);
      check_status("glitch_magic", 1'b0, 1'b0, 1'b1);

      // Reset in the middle of a word discards the frame.
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      check_status("mid_data", 1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      wait_clks(2);
      check_status("mid_rst_held", 1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      wait_clks(4);
      check_status("mid_rst_after", 1'b0, 1'b1, 1'b0);
      check("final_writes_left", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
